// File: rtl/axis_frame_pkg.sv
// axis_frame_pkg: constants, state encoding and LFSR helper shared by the frame generator and checker
package axis_frame_pkg;
    localparam logic [63:0] MAGIC_NUMBER = 64'hDEADBEEFCAFEBABE;
    localparam int DEFAULT_DATA_WORDS = 35;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    typedef enum logic [1:0] {HUNT = 2'd0, TS = 2'd1, DATA = 2'd2} frame_state_t;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: status counter that sticks at all-ones, with a clear that beats any increment
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) q <= '0;
        else q <= clr ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/axis_frame_checker.sv
// axis_frame_checker: AXI-Stream sink that syncs on the frame magic word and checks length,
// TLAST placement and timestamp continuity of each acquisition frame.
module axis_frame_checker
    import axis_frame_pkg::*;
#(
    parameter int          DATA_WORDS = DEFAULT_DATA_WORDS,
    parameter logic [63:0] MAGIC      = MAGIC_NUMBER,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             enable,
    input  logic             bp_en,
    input  logic             clear_counters,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_err,
    output logic [CNT_W-1:0] sync_drops,
    output logic [CNT_W-1:0] ts_errors,
    output logic [63:0]      last_timestamp,
    output logic [63:0]      last_xor,
    output logic [1:0]       state_dbg
);
    localparam int WC_W = $clog2(DATA_WORDS + 1);

    frame_state_t    state;
    logic [15:0]     lfsr;
    logic [WC_W-1:0] word_cnt;
    logic [63:0]     xor_acc, ts_cur, prev_ts;
    logic            have_prev, ts_bad;
    logic            accept, is_magic, ts_bad_now, last_word, term, good, ts_hit, drop;
    logic [63:0]     xor_nxt, ts_fin, xor_fin;

    assign s_axis_tready = enable && !(bp_en && lfsr[0]);
    assign state_dbg     = state;

    always_comb begin
        accept     = s_axis_tvalid && s_axis_tready;
        is_magic   = s_axis_tdata == MAGIC && !s_axis_tlast;
        ts_bad_now = have_prev && s_axis_tdata != prev_ts + 64'd1;
        last_word  = word_cnt == WC_W'(DATA_WORDS - 1);
        term       = accept && ((state == TS && s_axis_tlast) || (state == DATA && (s_axis_tlast || last_word)));
        good       = state == DATA && s_axis_tlast && last_word && !ts_bad;
        drop       = accept && state == HUNT && !is_magic;
        xor_nxt    = xor_acc ^ s_axis_tdata;
        ts_fin     = state == TS ? s_axis_tdata : ts_cur;
        xor_fin    = state == TS ? 64'd0 : xor_nxt;
        ts_hit     = state == TS ? ts_bad_now : ts_bad;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= HUNT;
            lfsr           <= LFSR_SEED;
            word_cnt       <= '0;
            xor_acc        <= '0;
            ts_cur         <= '0;
            prev_ts        <= '0;
            have_prev      <= 1'b0;
            ts_bad         <= 1'b0;
            last_timestamp <= '0;
            last_xor       <= '0;
            frame_done     <= 1'b0;
            frame_ok       <= 1'b0;
        end else begin
            lfsr       <= lfsr_next(lfsr);
            frame_done <= term;
            frame_ok   <= term && good;
            have_prev  <= clear_counters ? 1'b0 : term ? 1'b1 : have_prev;
            if (term) begin
                last_timestamp <= ts_fin;
                last_xor       <= xor_fin;
                prev_ts        <= ts_fin;
            end
            if (accept) begin
                case (state)
                    HUNT: state <= is_magic ? TS : HUNT;
                    TS: begin
                        ts_cur   <= s_axis_tdata;
                        word_cnt <= '0;
                        xor_acc  <= '0;
                        ts_bad   <= ts_bad_now;
                        state    <= s_axis_tlast ? HUNT : DATA;
                    end
                    DATA: begin
                        xor_acc  <= xor_nxt;
                        word_cnt <= word_cnt + 1'b1;
                        state    <= term ? HUNT : DATA;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    // Timestamp history goes with every terminated frame, so one gap costs one ts_error.
    sat_counter #(.CNT_W(CNT_W)) u_ok   (.clk(clk), .rstn(rstn), .clr(clear_counters), .inc(term && good),   .q(frames_ok));
    sat_counter #(.CNT_W(CNT_W)) u_err  (.clk(clk), .rstn(rstn), .clr(clear_counters), .inc(term && !good),  .q(frames_err));
    sat_counter #(.CNT_W(CNT_W)) u_drop (.clk(clk), .rstn(rstn), .clr(clear_counters), .inc(drop),           .q(sync_drops));
    sat_counter #(.CNT_W(CNT_W)) u_ts   (.clk(clk), .rstn(rstn), .clr(clear_counters), .inc(term && ts_hit), .q(ts_errors));
endmodule

// File: tb/tb_axis_frame_checker.sv
// tb_axis_frame_checker: randomized frame traffic checked against a frame-level parser model
module tb_axis_frame_checker;
    import axis_frame_pkg::*;
    localparam int DW = DEFAULT_DATA_WORDS;
    localparam logic [63:0] MAGIC = MAGIC_NUMBER;

    typedef struct {logic [63:0] d; logic l;} beat_t;

    logic        clk = 1'b0, rstn = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
    logic        enable = 1'b0, bp_en = 1'b0, clear_counters = 1'b0;
    logic        s_axis_tready, frame_done, frame_ok;
    logic [31:0] frames_ok, frames_err, sync_drops, ts_errors;
    logic [63:0] last_timestamp, last_xor;
    logic [1:0]  state_dbg;
    logic        s_tready, s_done, s_fok;
    logic [2:0]  s_ok, s_err, s_drop, s_ts;
    logic [63:0] s_last_ts, s_last_xor;
    logic [1:0]  s_state;

    axis_frame_checker dut (
        .clk(clk), .rstn(rstn), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .enable(enable), .bp_en(bp_en),
        .clear_counters(clear_counters), .frame_done(frame_done), .frame_ok(frame_ok),
        .frames_ok(frames_ok), .frames_err(frames_err), .sync_drops(sync_drops), .ts_errors(ts_errors),
        .last_timestamp(last_timestamp), .last_xor(last_xor), .state_dbg(state_dbg)
    );

    // Narrow-counter twin sees identical traffic and must stick at 7.
    axis_frame_checker #(.CNT_W(3)) dut_sat (
        .clk(clk), .rstn(rstn), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_axis_tlast), .enable(enable), .bp_en(bp_en),
        .clear_counters(clear_counters), .frame_done(s_done), .frame_ok(s_fok),
        .frames_ok(s_ok), .frames_err(s_err), .sync_drops(s_drop), .ts_errors(s_ts),
        .last_timestamp(s_last_ts), .last_xor(s_last_xor), .state_dbg(s_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, tl_cyc = 0, done_cyc = 0, n_done = 0, n_okp = 0;
    int gap_pct = 0;
    bit clr_last = 0;
    beat_t q[$];
    int m_ok, m_err, m_drop, m_tse, m_done, m_okp;
    bit m_have;
    logic [63:0] m_prev, m_last_ts, m_last_xor;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (frame_done) begin
            n_done   <= n_done + 1;
            n_okp    <= n_okp + (frame_ok ? 1 : 0);
            done_cyc <= cyc;
        end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat7(input int v);
        return v > 7 ? 7 : v;
    endfunction

    task automatic model_reset();
        m_ok = 0; m_err = 0; m_drop = 0; m_tse = 0;
        m_have = 0; m_prev = '0; m_last_ts = '0; m_last_xor = '0;
    endtask

    task automatic model_clear();
        m_ok = 0; m_err = 0; m_drop = 0; m_tse = 0; m_have = 0;
    endtask

    // Parses the queued stream as whole frames: magic, timestamp, then up to DW payload beats.
    task automatic model_run();
        int i, n;
        bit bad, good;
        logic [63:0] ts, x;
        i = 0;
        while (i < q.size()) begin
            if (q[i].d == MAGIC && !q[i].l && i + 1 < q.size()) begin
                ts = q[i+1].d; x = '0; n = 0; good = 0;
                bad = m_have && ts != m_prev + 64'd1;
                if (!q[i+1].l) begin
                    while (n < DW && i + 2 + n < q.size()) begin
                        x ^= q[i+2+n].d;
                        n++;
                        if (q[i+1+n].l) break;
                    end
                    good = n == DW && q[i+1+n].l && !bad;
                end
                if (good) begin m_ok++; m_okp++; end else m_err++;
                if (bad) m_tse++;
                m_done++;
                m_last_ts = ts; m_last_xor = x; m_prev = ts; m_have = 1;
                i += 2 + n;
            end else begin
                m_drop++;
                i++;
            end
        end
    endtask

    task automatic add_beat(input logic [63:0] d, input logic l);
        q.push_back('{d: d, l: l});
    endtask

    task automatic add_frame(input logic [63:0] ts, input int nw, input int last_at, input bit rnd);
        add_beat(MAGIC, 1'b0);
        add_beat(ts, 1'b0);
        for (int k = 1; k <= nw; k++)
            add_beat(rnd ? {$urandom, $urandom} : 64'(k - 1), k == last_at);
    endtask

    task automatic send();
        int w, g;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            g = (gap_pct > 0 && $urandom_range(99) < gap_pct) ? $urandom_range(4, 1) : 0;
            repeat (g) @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = q[k].d;
            s_axis_tlast  = q[k].l;
            w = 0;
            #4;
            while (!s_axis_tready && w < 2000) begin
                @(negedge clk);
                #4;
                w++;
            end
            if (w >= 2000) check("accept timeout", 64'd0, 64'd1);
            if (q[k].l) tl_cyc = cyc;
            if (clr_last && k == q.size() - 1) clear_counters = 1'b1;
            @(posedge clk);
            #1;
            clear_counters = 1'b0;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        q.delete();
    endtask

    task automatic flush();
        model_run();
        send();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_counters = 1'b1;
        @(negedge clk);
        clear_counters = 1'b0;
        model_clear();
    endtask

    task automatic check_all(input string s);
        check({s, " frames_ok"}, frames_ok, m_ok);
        check({s, " frames_err"}, frames_err, m_err);
        check({s, " sync_drops"}, sync_drops, m_drop);
        check({s, " ts_errors"}, ts_errors, m_tse);
        check({s, " last_ts"}, last_timestamp, m_last_ts);
        check({s, " last_xor"}, last_xor, m_last_xor);
        check({s, " state"}, state_dbg, 0);
        check({s, " done pulses"}, n_done, m_done);
        check({s, " ok pulses"}, n_okp, m_okp);
        check({s, " sat ok"}, s_ok, sat7(m_ok));
        check({s, " sat err"}, s_err, sat7(m_err));
        check({s, " sat drops"}, s_drop, sat7(m_drop));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        m_done = 0; m_okp = 0;
        repeat (3) @(negedge clk);
        check("rst frames_ok", frames_ok, 0);
        check("rst state", state_dbg, 0);
        check("rst frame_done", frame_done, 0);
        check("rst last_xor", last_xor, 0);
        check("rst tready", s_axis_tready, 0);
        rstn = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        add_frame(64'd5, DW, DW, 0);
        add_frame(64'd6, DW, DW, 0);
        flush();
        check_all("s1");
        check("s1 xor const", last_xor, 64'h23);
        check("s1 ok const", frames_ok, 2);

        do_clear();
        repeat (3) add_beat(64'h1111, 1'b0);
        add_frame(64'd100, DW, DW, 1);
        flush();
        check_all("s2");
        check("s2 done latency", done_cyc - tl_cyc, 1);

        do_clear();
        add_frame(64'd200, DW, 10, 1);
        add_frame(64'd201, DW, DW, 1);
        flush();
        check_all("s3");

        do_clear();
        add_frame(64'd7, DW, DW, 1);
        add_frame(64'd9, DW, DW, 1);
        add_frame(64'd10, DW, DW, 1);
        flush();
        check_all("s4");
        check("s4 ts const", ts_errors, 1);

        do_clear();
        add_frame(64'd300, DW, 0, 1);
        add_beat(64'h2222, 1'b0);
        add_beat(64'h3333, 1'b1);
        flush();
        check_all("s5");

        do_clear();
        bp_en = 1'b1;
        gap_pct = 30;
        for (int f = 0; f < 100; f++) add_frame(64'd1000 + 64'(f), DW, DW, 1);
        model_run();
        fork
            send();
            begin
                repeat (400) @(negedge clk);
                enable = 1'b0;
                repeat (20) @(negedge clk);
                enable = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check_all("s6");
        check("s6 ok const", frames_ok, 100);
        check("s6 sat ok const", s_ok, 7);

        add_frame(64'd5000, DW, DW, 1);
        clr_last = 1;
        model_run();
        send();
        clr_last = 0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all("s7 clr");
        add_frame({$urandom, $urandom}, DW, DW, 1);
        flush();
        check_all("s7 next");

        add_frame(64'd42, 5, 0, 1);
        send();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        model_reset();
        check("rst2 state", state_dbg, 0);
        check("rst2 last_ts", last_timestamp, 0);
        check("rst2 frames_ok", frames_ok, 0);
        @(negedge clk);
        rstn = 1'b1;
        add_frame({$urandom, $urandom}, DW, DW, 1);
        flush();
        check_all("s8");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
